// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with column synchroniser, frame debounce and new-key event.
// Optional macro KEYPAD_CHIP8_MAP_EN selects the CHIP-8 key layout instead of identity mapping.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1024,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  kp_col_in,
  output logic [3:0]  kp_row_out,
  output logic [15:0] keypad_matrix,
  output logic        key_event,
  output logic [3:0]  key_code
);

  // state | meaning
  // ROW0  | row 0 driven low, dwell counting
  // ROW1  | row 1 driven low, dwell counting
  // ROW2  | row 2 driven low, dwell counting
  // ROW3  | row 3 driven low; its sample completes the frame
  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_t;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  row_t          state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    col_meta, col_sync;
  logic [15:0]   raw, raw_nxt, prev_raw, new_keys;
  logic [SW-1:0] stable, stable_nxt;
  logic          sample, frame_done, frame_done_q, commit;

  function automatic logic [3:0] key_index(input logic [1:0] r, input logic [1:0] c);
`ifdef KEYPAD_CHIP8_MAP_EN
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hC;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hD;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
      4'hC: k = 4'hA;  4'hD: k = 4'h0;  4'hE: k = 4'hB;  default: k = 4'hF;
    endcase
    return k;
`else
    return {r, c};
`endif
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'h0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // Columns idle high; reset value keeps the first samples reading "no key".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= kp_col_in;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (sample) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

  assign sample     = (cnt == CNT_LAST);
  assign frame_done = sample && (state == ROW3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ROW0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sample) begin
      case (state)
        ROW0:    state_nxt = ROW1;
        ROW1:    state_nxt = ROW2;
        ROW2:    state_nxt = ROW3;
        default: state_nxt = ROW0;
      endcase
    end
  end

  always_comb begin
    case (state)
      ROW0:    kp_row_out = 4'b1110;
      ROW1:    kp_row_out = 4'b1101;
      ROW2:    kp_row_out = 4'b1011;
      default: kp_row_out = 4'b0111;
    endcase
  end

  always_comb begin
    raw_nxt = raw;
    for (int c = 0; c < 4; c++)
      raw_nxt[key_index(state, 2'(c))] = ~col_sync[c];
  end

  always_comb begin
    if (raw_nxt != prev_raw)     stable_nxt = SW'(1);
    else if (stable == STABLE_MAX) stable_nxt = stable;
    else                         stable_nxt = stable + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw          <= '0;
      prev_raw     <= '0;
      stable       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done;
      if (sample) raw <= raw_nxt;
      if (frame_done) begin
        prev_raw <= raw_nxt;
        stable   <= stable_nxt;
      end
    end
  end

  // raw still holds the completed frame one clock after the ROW3 sample.
  assign commit   = frame_done_q && (stable == STABLE_MAX) && (raw != keypad_matrix);
  assign new_keys = raw & ~keypad_matrix;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keypad_matrix <= '0;
      key_event     <= 1'b0;
      key_code      <= 4'h0;
    end else begin
      key_event <= 1'b0;
      if (commit) begin
        keypad_matrix <= raw;
        if (|new_keys) begin
          key_event <= 1'b1;
          key_code  <= lowest_set(new_keys);
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model, vector table of presses, reset/bounce/random sequences.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  kp_col_in;
  logic [3:0]  kp_row_out;
  logic [15:0] keypad_matrix;
  logic        key_event;
  logic [3:0]  key_code;

  logic [15:0] pressed = 16'h0000;
  int checks = 0;
  int failures = 0;
  int ev_count = 0;

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .reset(reset), .kp_col_in(kp_col_in), .kp_row_out(kp_row_out),
    .keypad_matrix(keypad_matrix), .key_event(key_event), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed switch at (r,c) pulls column c low while row r is driven.
  always_comb begin
    kp_col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp_row_out[r] && pressed[r*4+c]) kp_col_in[c] = 1'b0;
  end

  always @(posedge clk) if (key_event) ev_count++;

  typedef struct {
    logic [15:0] pressed;
    logic [15:0] matrix;
    logic        ev;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just after the ROW3 sample edge (row 0 freshly driven).
  task automatic align_frame();
    int guard = 0;
    while (kp_row_out == 4'b1110 && guard < 200) begin tick(1); guard++; end
    while (kp_row_out != 4'b1110 && guard < 200) begin tick(1); guard++; end
    if (guard >= 200) check("align_timeout", 1, 0);
  endtask

  initial begin
    logic [15:0] prev_matrix;
    logic [3:0]  prev_code;
    int ev0;
    logic prev_ev;

`ifdef KEYPAD_CHIP8_MAP_EN
    vecs.push_back('{16'h2000, 16'h0001, 1'b1, 4'h0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 4'h0});
    vecs.push_back('{16'h0008, 16'h1000, 1'b1, 4'hC});
    vecs.push_back('{16'h0009, 16'h1002, 1'b1, 4'h1});
    vecs.push_back('{16'h0010, 16'h0010, 1'b1, 4'h4});
`else
    vecs.push_back('{16'h0040, 16'h0040, 1'b1, 4'h6});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 4'h6});
    vecs.push_back('{16'h0208, 16'h0208, 1'b1, 4'h3});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 4'h3});
    vecs.push_back('{16'h0001, 16'h0001, 1'b1, 4'h0});
    vecs.push_back('{16'h0003, 16'h0003, 1'b1, 4'h1});
    vecs.push_back('{16'h0002, 16'h0002, 1'b0, 4'h1});
    vecs.push_back('{16'hF000, 16'hF000, 1'b1, 4'hC});
`endif

    reset = 1'b0;
    tick(3);
    check("rst_row", kp_row_out, 4'b1110);
    check("rst_matrix", keypad_matrix, 0);
    check("rst_event", key_event, 0);
    check("rst_code", key_code, 0);
    reset = 1'b1;

    prev_matrix = 16'h0000;
    prev_code   = 4'h0;
    foreach (vecs[i]) begin
      align_frame();
      pressed = vecs[i].pressed;
      ev0 = ev_count;
      tick(64);
      check($sformatf("v%0d_early_matrix", i), keypad_matrix, prev_matrix);
      check($sformatf("v%0d_early_event", i), key_event, 0);
      tick(1);
      check($sformatf("v%0d_matrix", i), keypad_matrix, vecs[i].matrix);
      check($sformatf("v%0d_event", i), key_event, vecs[i].ev);
      check($sformatf("v%0d_code", i), key_code, vecs[i].code);
      tick(1);
      check($sformatf("v%0d_pulse_end", i), key_event, 0);
      check($sformatf("v%0d_ev_count", i), ev_count - ev0, vecs[i].ev);
      prev_matrix = vecs[i].matrix;
      prev_code   = vecs[i].code;
    end

    // Reset while ROW2 is driven with a committed key held.
    begin
      int guard = 0;
      while (kp_row_out != 4'b1011 && guard < 200) begin tick(1); guard++; end
      if (guard >= 200) check("row2_timeout", 1, 0);
    end
    tick(3);
    check("pre_rst_matrix", keypad_matrix, prev_matrix);
    #1 reset = 1'b0;
    #1;
    check("midrst_row", kp_row_out, 4'b1110);
    check("midrst_matrix", keypad_matrix, 0);
    check("midrst_event", key_event, 0);
    check("midrst_code", key_code, 0);
    pressed = 16'h0000;
    tick(2);
    reset = 1'b1;
    tick(7);
    check("rel_row_7", kp_row_out, 4'b1110);
    tick(1);
    check("rel_row_8", kp_row_out, 4'b1101);
    tick(8);
    check("rel_row_16", kp_row_out, 4'b1011);

    // Bounce: key (r0,c0) present in alternate frames only.
    ev0 = ev_count;
    for (int f = 0; f < 10; f++) begin
      align_frame();
      check($sformatf("bounce_matrix_f%0d", f), keypad_matrix, 0);
      pressed = (f % 2 == 0) ? 16'h0001 : 16'h0000;
    end
    align_frame();
    check("bounce_matrix_end", keypad_matrix, 0);
    check("bounce_events", ev_count - ev0, 0);
    pressed = 16'h0000;

    // Random column stimulus over 100 frames.
    prev_ev = 1'b0;
    for (int n = 0; n < 3200; n++) begin
      if (n % 80 == 0) pressed = 16'($urandom);
      tick(1);
      check("row_one_low", $countones(~kp_row_out), 1);
      check("event_not_back_to_back", prev_ev && key_event, 0);
      prev_ev = key_event;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
